// File: rtl/alien_hit_detector.sv
// Per-frame missile-versus-fleet hit test with registered hit / missile_clear strobes.
// Optional macro HIT_LOCKOUT_EN: ignore LOCKOUT_TICKS frame ticks after each kill.
module alien_hit_detector #(
  parameter int unsigned FLEET_COLS    = 10,
  parameter int unsigned FLEET_ROWS    = 6,
  parameter int unsigned PITCH_X       = 48,
  parameter int unsigned PITCH_Y       = 32,
  parameter int unsigned ALIEN_W       = 32,
  parameter int unsigned ALIEN_H       = 24,
  parameter int unsigned LOCKOUT_TICKS = 4
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic                                 frame_tick,
  input  logic                                 missile_active,
  input  logic [9:0]                           missile_x,
  input  logic [9:0]                           missile_y,
  input  logic [9:0]                           fleet_x,
  input  logic [9:0]                           fleet_y,
  input  logic [FLEET_COLS-1:0][FLEET_ROWS-1:0] alien_grid,
  output logic [6:0]                           alien_hit,
  output logic                                 hit,
  output logic                                 missile_clear,
  output logic                                 busy
);

  localparam logic [9:0] PX       = 10'(PITCH_X);
  localparam logic [9:0] PY       = 10'(PITCH_Y);
  localparam logic [9:0] AW       = 10'(ALIEN_W);
  localparam logic [9:0] AH       = 10'(ALIEN_H);
  localparam logic [3:0] LAST_COL = 4'(FLEET_COLS - 1);
  localparam logic [2:0] LAST_ROW = 3'(FLEET_ROWS - 1);
  localparam int unsigned LOCK_W  = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_DIV_X, S_DIV_Y, S_CHECK, S_SETUP, S_PULSE
  } state_t;

  state_t                               state_q, state_d;
  logic [9:0]                           dx_q, dx_d, dy_q, dy_d;
  logic [3:0]                           col_q, col_d;
  logic [2:0]                           row_q, row_d;
  logic [FLEET_COLS-1:0][FLEET_ROWS-1:0] grid_q, grid_d;
  logic [6:0]                           alien_hit_q;
  logic                                 hit_q, clear_q, busy_q;
  logic [LOCK_W-1:0]                    lock_q;
  logic                                 locked;

  assign locked = (lock_q != '0);

`ifdef HIT_LOCKOUT_EN
  logic [LOCK_W-1:0] lock_d;

  always_comb begin
    lock_d = lock_q;
    if (state_q == S_PULSE)
      lock_d = LOCK_W'(LOCKOUT_TICKS);
    else if (state_q == S_IDLE && frame_tick && locked)
      lock_d = lock_q - 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) lock_q <= '0;
    else       lock_q <= lock_d;
  end
`else
  assign lock_q = '0;
`endif

  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    col_d   = col_q;
    row_d   = row_q;
    grid_d  = grid_q;
    unique case (state_q)
      S_IDLE:
        if (frame_tick && missile_active && !locked) state_d = S_LATCH;
      S_LATCH: begin
        grid_d  = alien_grid;
        dx_d    = missile_x - fleet_x;
        dy_d    = missile_y - fleet_y;
        col_d   = '0;
        row_d   = '0;
        state_d = (missile_x < fleet_x || missile_y < fleet_y) ? S_IDLE : S_DIV_X;
      end
      // Repeated subtraction: quotient lands in col/row, remainder is the offset inside the cell.
      S_DIV_X:
        if (dx_q >= PX) begin
          if (col_q == LAST_COL) state_d = S_IDLE;
          else begin
            dx_d  = dx_q - PX;
            col_d = col_q + 4'd1;
          end
        end else state_d = S_DIV_Y;
      S_DIV_Y:
        if (dy_q >= PY) begin
          if (row_q == LAST_ROW) state_d = S_IDLE;
          else begin
            dy_d  = dy_q - PY;
            row_d = row_q + 3'd1;
          end
        end else state_d = S_CHECK;
      S_CHECK:
        state_d = (dx_q < AW && dy_q < AH && grid_q[col_q][row_q]) ? S_SETUP : S_IDLE;
      S_SETUP: state_d = S_PULSE;
      S_PULSE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!missile_active && state_q != S_IDLE && state_q != S_PULSE) state_d = S_IDLE;
  end

  // Strobes are decoded from the next state so they leave a flop, not a decoder.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      dx_q        <= '0;
      dy_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      grid_q      <= '0;
      alien_hit_q <= '0;
      hit_q       <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      col_q   <= col_d;
      row_q   <= row_d;
      grid_q  <= grid_d;
      if (state_d == S_SETUP) alien_hit_q <= {col_q, row_q};
      hit_q   <= (state_d == S_PULSE);
      clear_q <= (state_d == S_PULSE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign alien_hit     = alien_hit_q;
  assign hit           = hit_q;
  assign missile_clear = clear_q;
  assign busy          = busy_q;

endmodule
